// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: latches call buttons and paces the elevator FSM through travel and door dwell
module elevator_call_scheduler #(
  parameter int DOOR_CYCLES   = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] btn_raw,
  input  logic [2:0] floor_ind,
  input  logic       door_open,
  input  logic [6:0] clr_in,
  output logic [6:0] req_out,
  output logic [6:0] pend_lamp,
  output logic       moving,
  output logic [1:0] sched_state
);
  localparam int TW = $clog2(DOOR_CYCLES > TRAVEL_CYCLES ? DOOR_CYCLES : TRAVEL_CYCLES);
  typedef enum logic [1:0] {READY, TRAVEL, DWELL, CLOSE} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [SYNC_STAGES-1:0][6:0] sync_q;
  logic [6:0] sync_prev, btn_rise, pend, clr_cap, clr_cap_n, clr_mask;
  logic [2:0] floor_q;
  logic trav, pass, reopen;
  assign btn_rise    = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign trav        = floor_ind != floor_q;
  assign pass        = !trav && state != TRAVEL;
  assign reopen      = |(btn_rise & clr_cap);
  assign req_out     = pend & {7{pass}};
  assign pend_lamp   = pend;
  assign moving      = trav || state == TRAVEL;
  assign sched_state = state;
  // synchronise raw buttons, keep the last synced level for edge detect, track floor
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q    <= '0;
      sync_prev <= '0;
      floor_q   <= 3'b100;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      sync_prev <= sync_q[SYNC_STAGES-1];
      floor_q   <= floor_ind;
    end
  // scheduler state, timer, captured clears and pending calls (commit-clear beats a new press)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= READY;
      timer   <= '0;
      clr_cap <= '0;
      pend    <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      clr_cap <= clr_cap_n;
      pend    <= (pend | btn_rise) & ~clr_mask;
    end
  // next-state logic; a press on a captured call re-opens the door by reloading the dwell timer
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    clr_cap_n = clr_cap;
    clr_mask  = '0;
    case (state)
      READY:
        if (trav) begin
          state_n = TRAVEL;
          timer_n = TW'(TRAVEL_CYCLES - 1);
        end else if (door_open) begin
          state_n   = DWELL;
          timer_n   = TW'(DOOR_CYCLES - 1);
          clr_cap_n = clr_in;
        end
      TRAVEL: begin
        state_n = timer == '0 ? READY : TRAVEL;
        timer_n = timer == '0 ? timer : timer - 1'b1;
      end
      DWELL: begin
        clr_cap_n = clr_cap | clr_in;
        if (reopen)
          timer_n = TW'(DOOR_CYCLES - 1);
        else if (timer == '0) begin
          state_n  = CLOSE;
          clr_mask = clr_cap | clr_in;
        end else
          timer_n = timer - 1'b1;
      end
      CLOSE:
        if (!door_open) begin
          state_n   = READY;
          clr_cap_n = '0;
        end else begin
          state_n   = DWELL;
          timer_n   = TW'(DOOR_CYCLES - 1);
          clr_cap_n = clr_in;
        end
      default: state_n = READY;
    endcase
  end
endmodule
